// File: rtl/rv_mem_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM encoding,
// requester identifiers and the full-word byte-enable constant.
package rv_mem_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned BE_W    = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam logic [BE_W-1:0] BE_WORD = 4'hF;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Counts wait cycles of the in-flight memory transaction and flags the last
// allowed cycle so the arbiter can force an error completion.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Saturates at LAST so a stalled enable can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and
// load/store, data first with a burst limit, one transaction at a time.
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned MAX_DBURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic [AW-1:0]   fetch_addr,
  output logic            fetch_done,
  output logic [DW-1:0]   fetch_rdata,
  input  logic            data_req,
  input  logic            data_we,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  input  logic [BE_W-1:0] data_be,
  output logic            data_done,
  output logic [DW-1:0]   data_rdata,
  output logic            bus_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned BW = $clog2(MAX_DBURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DBURST);

  state_t        state;
  state_t        next_state;
  logic [BW-1:0] burst_cnt;
  logic          idle;
  logic          busy;
  logic          launch_data;
  logic          launch_fetch;
  logic          expired;
  logic          finish;
  logic          timed_out;

  // Grant decision: data wins unless fetch has waited through a full burst.
  always_comb begin
    idle         = (state == ST_IDLE);
    busy         = (state == ST_FETCH) || (state == ST_DATA);
    launch_data  = idle && data_req && (!fetch_req || (burst_cnt < BURST_MAX));
    launch_fetch = idle && fetch_req && !launch_data;
    finish       = busy && (mem_ready || expired);
    timed_out    = busy && expired && !mem_ready;
  end

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (idle),
    .enable  (busy),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (launch_data) begin
          next_state = ST_DATA;
        end else if (launch_fetch) begin
          next_state = ST_FETCH;
        end
      end
      ST_FETCH, ST_DATA: begin
        if (finish) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Request latch, burst accounting and completion reporting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      burst_cnt   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      fetch_done  <= 1'b0;
      data_done   <= 1'b0;
      bus_err     <= 1'b0;
      fetch_rdata <= '0;
      data_rdata  <= '0;
    end else begin
      mem_req    <= (next_state == ST_FETCH) || (next_state == ST_DATA);
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
      bus_err    <= 1'b0;

      if (launch_data) begin
        mem_addr  <= data_addr;
        mem_we    <= data_we;
        mem_wdata <= data_wdata;
        mem_be    <= data_be;
        if (!fetch_req) begin
          burst_cnt <= '0;
        end else if (burst_cnt != BURST_MAX) begin
          burst_cnt <= burst_cnt + BW'(1);
        end
      end else if (launch_fetch) begin
        mem_addr  <= fetch_addr;
        mem_we    <= 1'b0;
        mem_wdata <= '0;
        mem_be    <= BE_WORD;
        burst_cnt <= '0;
      end

      if (finish) begin
        bus_err <= timed_out;
        if (state == ST_FETCH) begin
          fetch_done  <= 1'b1;
          fetch_rdata <= timed_out ? '0 : mem_rdata;
        end else begin
          data_done <= 1'b1;
          if (timed_out) begin
            data_rdata <= '0;
          end else if (!mem_we) begin
            data_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand
// sequences for burst limit / reset, and random transactions vs a model.
module tb_mem_port_arbiter;

  localparam int unsigned AW         = 32;
  localparam int unsigned DW         = 32;
  localparam int unsigned TIMEOUT    = 8;
  localparam int unsigned MAX_DBURST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_done;
  logic [DW-1:0] fetch_rdata;
  logic          data_req;
  logic          data_we;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [3:0]    data_be;
  logic          data_done;
  logic [DW-1:0] data_rdata;
  logic          bus_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .MAX_DBURST(MAX_DBURST)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_done(fetch_done), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_be(data_be),
    .data_done(data_done), .data_rdata(data_rdata), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        f;
    logic        d;
    logic        we;
    logic [31:0] faddr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] rdata;
    logic        drop;
    logic        exp_data;
    logic        exp_err;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          streak = 0;
  logic [31:0] m_frd = '0;
  logic [31:0] m_drd = '0;
  vec_t        vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic f, input logic d, input logic we,
                              input logic [31:0] faddr, input logic [31:0] daddr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input int waits, input logic [31:0] rdata,
                              input logic drop, input logic exp_data, input logic exp_err);
    vec_t v;
    v.f = f; v.d = d; v.we = we; v.faddr = faddr; v.daddr = daddr;
    v.wdata = wdata; v.be = be; v.waits = waits; v.rdata = rdata;
    v.drop = drop; v.exp_data = exp_data; v.exp_err = exp_err;
    return v;
  endfunction

  // One complete transaction, with the expected grant and error outcome supplied by the caller.
  task automatic run_txn(input vec_t v);
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic        ewe;
    int          fin;
    int          n;
    logic        done_seen;
    logic        unstable;
    fin = (v.waits < int'(TIMEOUT) - 1) ? v.waits : int'(TIMEOUT) - 1;
    eaddr = v.exp_data ? v.daddr : v.faddr;
    ebe   = v.exp_data ? v.be : 4'hF;
    ewe   = v.exp_data ? v.we : 1'b0;
    if (v.exp_data) streak = v.f ? ((streak < int'(MAX_DBURST)) ? streak + 1 : streak) : 0;
    else streak = 0;

    fetch_req = v.f; data_req = v.d; data_we = v.we;
    fetch_addr = v.faddr; data_addr = v.daddr; data_wdata = v.wdata; data_be = v.be;
    mem_ready = 1'b0;
    tick();
    check("req_latency", mem_req, 1'b1);
    if (mem_req !== 1'b1) begin
      fetch_req = 1'b0; data_req = 1'b0;
      for (int i = 0; i < int'(TIMEOUT) + 4; i++) tick();
      return;
    end
    check("mem_addr", mem_addr, eaddr);
    check("mem_we", mem_we, ewe);
    check("mem_be", mem_be, ebe);
    if (v.exp_data) check("mem_wdata", mem_wdata, v.wdata);
    if (v.drop) begin fetch_req = 1'b0; data_req = 1'b0; end

    n = 0; done_seen = 1'b0; unstable = 1'b0;
    for (int k = 0; k < int'(TIMEOUT) + 4; k++) begin
      mem_ready = (k == v.waits);
      mem_rdata = (k == v.waits) ? v.rdata : $urandom;
      tick();
      n++;
      if (fetch_done || data_done) begin
        done_seen = 1'b1;
        break;
      end
      if (mem_req !== 1'b1 || mem_addr !== eaddr || mem_be !== ebe || mem_we !== ewe ||
          (v.exp_data && mem_wdata !== v.wdata)) unstable = 1'b1;
    end
    mem_ready = 1'b0;
    check("done_seen", done_seen, 1'b1);
    check("mem_stable", unstable, 1'b0);
    check("done_latency", n, fin + 1);
    check("fetch_done", fetch_done, !v.exp_data);
    check("data_done", data_done, v.exp_data);
    check("bus_err", bus_err, v.exp_err);
    check("mem_req_resp", mem_req, 1'b0);
    if (v.exp_data) begin
      if (v.exp_err) m_drd = '0;
      else if (!v.we) m_drd = v.rdata;
    end else begin
      m_frd = v.exp_err ? '0 : v.rdata;
    end
    check("fetch_rdata", fetch_rdata, m_frd);
    check("data_rdata", data_rdata, m_drd);
    fetch_req = 1'b0; data_req = 1'b0;
    tick();
    check("done_pulse_1cyc", {fetch_done, data_done, bus_err}, 3'b000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    logic [31:0] t3_addr[6];
    logic        got;

    reset = 1'b0; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0; data_be = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick(); tick();
    check("reset_ctrl", {fetch_done, data_done, bus_err, mem_req, mem_we, mem_be}, 9'h0);
    check("reset_addr", mem_addr, 32'h0);
    check("reset_wdata", mem_wdata, 32'h0);
    check("reset_frd", fetch_rdata, 32'h0);
    check("reset_drd", data_rdata, 32'h0);
    reset = 1'b1;
    tick();

    //          f  d  we faddr         daddr         wdata         be     w   rdata         drop D  E
    vecs[0] = mk(1, 0, 0, 32'h100,      32'h0,        32'h0,        4'h0,  0,  32'h00500093, 0, 0, 0);
    vecs[1] = mk(1, 1, 0, 32'h104,      32'h200,      32'h0,        4'hF,  0,  32'h11112222, 0, 1, 0);
    vecs[2] = mk(1, 0, 0, 32'h104,      32'h0,        32'h0,        4'h0,  1,  32'h00000013, 0, 0, 0);
    vecs[3] = mk(0, 1, 1, 32'h0,        32'h300,      32'hDEADBEEF, 4'h3,  5,  32'h77777777, 0, 1, 0);
    vecs[4] = mk(0, 1, 0, 32'h0,        32'h304,      32'h0,        4'hF,  7,  32'hCAFEF00D, 0, 1, 0);
    vecs[5] = mk(0, 1, 0, 32'h0,        32'h308,      32'h0,        4'hF,  20, 32'h55555555, 0, 1, 1);
    vecs[6] = mk(1, 0, 0, 32'h108,      32'h0,        32'h0,        4'h0,  8,  32'h66666666, 0, 0, 1);
    vecs[7] = mk(1, 0, 0, 32'h10C,      32'h0,        32'h0,        4'h0,  3,  32'h12345678, 1, 0, 0);
    vecs[8] = mk(0, 1, 0, 32'h0,        32'h30C,      32'h0,        4'hC,  2,  32'hA5A5A5A5, 1, 1, 0);
    vecs[9] = mk(1, 1, 1, 32'h110,      32'h310,      32'h01020304, 4'h1,  0,  32'h99999999, 0, 1, 0);
    for (int i = 0; i < 10; i++) run_txn(vecs[i]);
    // Last vector left one data grant charged against the pending fetch; clear it.
    run_txn(mk(1, 0, 0, 32'h114, 32'h0, 32'h0, 4'h0, 0, 32'h00000073, 0, 0, 0));

    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ready_ignored", {fetch_done, data_done, bus_err, mem_req}, 4'h0);
    end
    mem_ready = 1'b0;

    // Both requesters held: D,D,D,D,F then D again.
    t3_addr[0] = 32'h2000; t3_addr[1] = 32'h2000; t3_addr[2] = 32'h2000;
    t3_addr[3] = 32'h2000; t3_addr[4] = 32'h1000; t3_addr[5] = 32'h2000;
    fetch_req = 1'b1; fetch_addr = 32'h1000;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h2000; data_be = 4'hF;
    for (int g = 0; g < 6; g++) begin
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
        tick();
        got = mem_req;
      end
      check("burst_req_seen", got, 1'b1);
      if (!got) break;
      check("burst_grant", mem_addr, t3_addr[g]);
      mem_ready = 1'b1; mem_rdata = 32'h3000 + 32'(g);
      tick();
      mem_ready = 1'b0;
      check("burst_done", {fetch_done, data_done}, (t3_addr[g] == 32'h1000) ? 2'b10 : 2'b01);
      if (t3_addr[g] == 32'h1000) m_frd = 32'h3000 + 32'(g);
      else m_drd = 32'h3000 + 32'(g);
    end
    check("burst_frd", fetch_rdata, m_frd);
    check("burst_drd", data_rdata, m_drd);
    fetch_req = 1'b0; data_req = 1'b0;
    tick();
    streak = 1;

    for (int r = 0; r < 60; r++) begin
      v.f = 1'($urandom_range(0, 1));
      v.d = v.f ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      v.we = 1'($urandom_range(0, 1));
      v.faddr = $urandom & 32'hFFFF_FFFC;
      v.daddr = $urandom;
      v.wdata = $urandom;
      v.be = 4'($urandom_range(0, 15));
      v.exp_data = v.d && (!v.f || streak < int'(MAX_DBURST));
      v.waits = (v.exp_data && v.we) ? $urandom_range(0, 6) : $urandom_range(0, 10);
      v.rdata = $urandom;
      v.drop = ($urandom_range(0, 3) == 0);
      v.exp_err = (v.waits >= int'(TIMEOUT));
      run_txn(v);
    end

    // Reset during the third FETCH cycle aborts without a done pulse.
    fetch_req = 1'b1; fetch_addr = 32'h400;
    tick(); tick(); tick();
    check("t6_in_fetch", mem_req, 1'b1);
    reset = 1'b0;
    tick();
    check("t6_mem_req", mem_req, 1'b0);
    check("t6_ctrl", {fetch_done, data_done, bus_err, mem_we, mem_be}, 8'h0);
    check("t6_addr", mem_addr, 32'h0);
    check("t6_rdata", {fetch_rdata, data_rdata}, 64'h0);
    fetch_req = 1'b0;
    tick();
    check("t6_no_done", {fetch_done, data_done}, 2'b00);
    reset = 1'b1;
    m_frd = '0; m_drd = '0; streak = 0;
    tick();
    run_txn(mk(1, 0, 0, 32'h500, 32'h0, 32'h0, 4'h0, 0, 32'h0badf00d, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
